fsm_out_monitor: RTL

FSM_OUT_MONITOR -- requirements
Module: fsm_out_monitor

---
 rtl/fsm_out_monitor.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fsm_out_monitor.sv
// fsm_out_monitor: observes the s / bs / f outputs of an upstream FSM and
// keeps registered statistics (s rising-edge count, bs run length, longest
// bs run, stuck flag) plus a small monitor state machine that tracks
// IDLE / ACTIVE / LOOP / HALT.
//
// Inputs are sampled at the rising edge of clk, and every output comes from a
// register, so no input reaches an output combinationally.
// rst clears everything asynchronously.
// clr is a synchronous clear and wins over f.
// f freezes the statistics on the edge that enters HALT and for as long as the
// block stays in HALT.
module fsm_out_monitor #(
  parameter int WIDTH    = 8,
  parameter int BS_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             s,
  input  logic             bs,
  input  logic             f,
  output logic [WIDTH-1:0] s_cnt,
  output logic [WIDTH-1:0] bs_run,
  output logic [WIDTH-1:0] bs_max,
  output logic             stuck,
  output logic             halted,
  output logic [1:0]       mode
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    LOOP   = 2'b10,
    HALT   = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] MAXV  = '1;
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LIMIT = BS_LIMIT[WIDTH-1:0];

  mode_t            state;
  mode_t            state_next;
  logic             s_prev;
  logic             s_rise;
  logic             freeze;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] run_next;
  logic [WIDTH-1:0] max_next;
  logic             stuck_next;

  assign s_rise = s & ~s_prev;

  // Statistics hold on the edge that enters HALT and while the block is in HALT.
  assign freeze = f | (state == HALT);

  // Monitor state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next monitor state: clr first, then f, then the normal transitions.
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = IDLE;
    end else if (f) begin
      state_next = HALT;
    end else begin
      case (state)
        IDLE:    if (s_rise) state_next = ACTIVE;
        ACTIVE:  if (bs)     state_next = LOOP;
        LOOP:    if (!bs)    state_next = ACTIVE;
        default: state_next = HALT;
      endcase
    end
  end

  // Decode the monitor outputs from the registered state.
  always_comb begin
    mode   = state;
    halted = (state == HALT);
  end

  // Next values of the statistics, with saturating counters.
  always_comb begin
    cnt_next   = s_cnt;
    run_next   = bs_run;
    max_next   = bs_max;
    stuck_next = stuck;
    if (clr) begin
      cnt_next   = '0;
      run_next   = '0;
      max_next   = '0;
      stuck_next = 1'b0;
    end else if (!freeze) begin
      if (s_rise && (s_cnt != MAXV)) cnt_next = s_cnt + ONE;
      if (bs) run_next = (bs_run == MAXV) ? bs_run : (bs_run + ONE);
      else    run_next = '0;
      max_next   = (run_next > bs_max) ? run_next : bs_max;
      stuck_next = bs && (run_next >= LIMIT);
    end
  end

  // Statistics registers.
  // s_prev tracks s on every edge, so releasing clr or HALT cannot fake an s edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev <= 1'b0;
      s_cnt  <= '0;
      bs_run <= '0;
      bs_max <= '0;
      stuck  <= 1'b0;
    end else begin
      s_prev <= s;
      s_cnt  <= cnt_next;
      bs_run <= run_next;
      bs_max <= max_next;
      stuck  <= stuck_next;
    end
  end

endmodule
